// File: rtl/reg_file_gen_v.sv
// Parametrised register block: ID string, status, control, scratch and saturating event counters.
// Optional 64-bit free-running cycle counter enabled by defining REG_FREERUN_CNT_EN.
module reg_file_gen_v #(
  parameter logic [511:0] PROJECT_NAME_G = 512'("NULLVERILOG"),
  parameter int unsigned  NAME_WORDS_G   = 4,
  parameter int unsigned  NUM_SCRATCH_G  = 4,
  parameter int unsigned  NUM_CNT_G      = 2,
  parameter int unsigned  CNT_WIDTH_G    = 16,
  parameter logic [31:0]  CTRL_RST_G     = 32'h0
) (
  input  logic                 reg_clk,
  input  logic                 reg_rst_n,
  input  logic                 reg_avld,
  input  logic [15:0]          reg_addr,
  input  logic                 reg_wvld,
  input  logic [31:0]          reg_wdata,
  output logic                 reg_rvld,
  output logic [31:0]          reg_rdata,
  input  logic [2:0]           fpga_id,
  input  logic [NUM_CNT_G-1:0] cnt_event,
  output logic [31:0]          ctrl_out
);

  // Literal is right-aligned in the vector; shift it so the first character is the top byte.
  function automatic logic [511:0] left_justify(input logic [511:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (s[8*i +: 8] != 8'h0) n = i + 1;
    end
    return s << (8 * (64 - n));
  endfunction

  localparam logic [511:0] NameJust = left_justify(PROJECT_NAME_G);
  localparam int unsigned AddrStat = NAME_WORDS_G;
  localparam int unsigned AddrCtrl = NAME_WORDS_G + 1;
  localparam int unsigned AddrScr  = NAME_WORDS_G + 2;
  localparam int unsigned AddrCnt  = AddrScr + NUM_SCRATCH_G;
`ifdef REG_FREERUN_CNT_EN
  localparam int unsigned AddrFrLo = AddrCnt + NUM_CNT_G;
  localparam int unsigned AddrFrHi = AddrFrLo + 1;
  localparam logic        FrEn     = 1'b1;
`else
  localparam logic        FrEn     = 1'b0;
`endif

  logic [15:0]            addr_q, addr_d;
  logic                   wvld_q;
  logic [31:0]            wdata_q;
  logic                   rvld_q;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            ctrl_q, ctrl_d;
  logic                   bad_addr_q, bad_addr_d;
  logic [31:0]            scratch_q [NUM_SCRATCH_G];
  logic [31:0]            scratch_d [NUM_SCRATCH_G];
  logic [CNT_WIDTH_G-1:0] cnt_q [NUM_CNT_G];
  logic [CNT_WIDTH_G-1:0] cnt_d [NUM_CNT_G];
  logic [31:0]            a;
  logic                   hit;
`ifdef REG_FREERUN_CNT_EN
  logic [63:0]            fr_q, fr_d;
  logic [31:0]            fr_hi_q, fr_hi_d;
`endif

  assign addr_d    = reg_avld ? reg_addr : addr_q;
  assign a         = {16'h0, addr_q};
  assign reg_rvld  = rvld_q;
  assign reg_rdata = rdata_q;
  assign ctrl_out  = ctrl_q;

  // Read decode of the latched address; hit=0 marks an out-of-range access.
  always_comb begin
    rdata_d = '0;
    hit     = 1'b0;
    for (int unsigned k = 0; k < NAME_WORDS_G; k++) begin
      if (a == k) begin
        hit     = 1'b1;
        rdata_d = NameJust[511-32*k -: 32];
      end
    end
    if (a == AddrStat) begin
      hit     = 1'b1;
      rdata_d = {bad_addr_q, 6'h0, FrEn, 8'(NUM_CNT_G), 8'(NUM_SCRATCH_G), 5'h0, fpga_id};
    end
    if (a == AddrCtrl) begin
      hit     = 1'b1;
      rdata_d = ctrl_q;
    end
    for (int unsigned i = 0; i < NUM_SCRATCH_G; i++) begin
      if (a == AddrScr + i) begin
        hit     = 1'b1;
        rdata_d = scratch_q[i];
      end
    end
    for (int unsigned i = 0; i < NUM_CNT_G; i++) begin
      if (a == AddrCnt + i) begin
        hit     = 1'b1;
        rdata_d = 32'(cnt_q[i]);
      end
    end
`ifdef REG_FREERUN_CNT_EN
    if (a == AddrFrLo) begin
      hit     = 1'b1;
      rdata_d = fr_q[31:0];
    end
    if (a == AddrFrHi) begin
      hit     = 1'b1;
      rdata_d = fr_hi_q;
    end
`endif
  end

  // Write commit and counter updates; every edge is also a read of the latched address.
  always_comb begin
    ctrl_d     = ctrl_q;
    bad_addr_d = bad_addr_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    if (wvld_q && a == AddrCtrl) ctrl_d = wdata_q;
    if (wvld_q && a == AddrStat && wdata_q[31]) bad_addr_d = 1'b0;
    if (!hit) bad_addr_d = 1'b1;
    for (int unsigned i = 0; i < NUM_SCRATCH_G; i++) begin
      if (wvld_q && a == AddrScr + i) scratch_d[i] = wdata_q;
    end
    for (int unsigned i = 0; i < NUM_CNT_G; i++) begin
      if (cnt_event[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_WIDTH_G'(1);
      if (wvld_q && a == AddrCnt + i) cnt_d[i] = '0;
    end
  end

`ifdef REG_FREERUN_CNT_EN
  always_comb begin
    fr_d    = fr_q + 64'd1;
    fr_hi_d = fr_hi_q;
    if (wvld_q && (a == AddrFrLo || a == AddrFrHi)) fr_d = '0;
    if (a == AddrFrLo) fr_hi_d = fr_q[63:32];
  end

  always_ff @(posedge reg_clk) begin
    if (!reg_rst_n) begin
      fr_q    <= '0;
      fr_hi_q <= '0;
    end else begin
      fr_q    <= fr_d;
      fr_hi_q <= fr_hi_d;
    end
  end
`endif

  always_ff @(posedge reg_clk) begin
    if (!reg_rst_n) begin
      addr_q     <= '0;
      wvld_q     <= 1'b0;
      wdata_q    <= '0;
      rvld_q     <= 1'b0;
      rdata_q    <= '0;
      ctrl_q     <= CTRL_RST_G;
      bad_addr_q <= 1'b0;
      scratch_q  <= '{default: '0};
      cnt_q      <= '{default: '0};
    end else begin
      addr_q     <= addr_d;
      wvld_q     <= reg_wvld;
      wdata_q    <= reg_wdata;
      rvld_q     <= 1'b1;
      rdata_q    <= rdata_d;
      ctrl_q     <= ctrl_d;
      bad_addr_q <= bad_addr_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_file_gen_v.sv
// Scoreboard bench for reg_file_gen_v: stimulus queues expected bus/ctrl values, a monitor checks.
module tb_reg_file_gen_v;

`ifdef REG_FREERUN_CNT_EN
  localparam logic [31:0] Stat = 32'h0102_0405;
`else
  localparam logic [31:0] Stat = 32'h0002_0405;
`endif
  localparam logic [31:0] Bad = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        avld;
  logic [15:0] addr;
  logic        wvld;
  logic [31:0] wdata;
  logic        rvld;
  logic [31:0] rdata;
  logic [2:0]  fpga_id;
  logic [1:0]  cnt_event;
  logic [31:0] ctrl_out;

  reg_file_gen_v #(
    .CNT_WIDTH_G (4)
  ) dut (
    .reg_clk   (clk),
    .reg_rst_n (rst_n),
    .reg_avld  (avld),
    .reg_addr  (addr),
    .reg_wvld  (wvld),
    .reg_wdata (wdata),
    .reg_rvld  (rvld),
    .reg_rdata (rdata),
    .fpga_id   (fpga_id),
    .cnt_event (cnt_event),
    .ctrl_out  (ctrl_out)
  );

  typedef struct {
    int          due;
    bit          sel;   // 0: {rvld, rdata}, 1: ctrl_out
    logic [32:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Monitor: pops every expectation that falls due on this edge.
  always @(posedge clk) begin
    chk_t        it;
    logic [32:0] act;
    cyc++;
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      it  = q.pop_front();
      act = it.sel ? {1'b0, ctrl_out} : {rvld, rdata};
      total++;
      if (it.due != cyc || act !== it.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h (cycle %0d)", it.name, act, it.exp, cyc);
      end
    end
  end

  task automatic push(input int due, input bit sel, input logic [32:0] exp, input string name);
    chk_t it;
    it.due  = due;
    it.sel  = sel;
    it.exp  = exp;
    it.name = name;
    q.push_back(it);
  endtask

  task automatic xfer(input logic [15:0] ad, input bit wr, input logic [31:0] d,
                      input bit chk, input logic [31:0] exp, input string name);
    avld  = 1'b1;
    addr  = ad;
    wvld  = wr;
    wdata = d;
    if (chk) push(cyc + 2, 1'b0, {1'b1, exp}, name);
    @(negedge clk);
    avld = 1'b0;
    wvld = 1'b0;
  endtask

  task automatic rd(input logic [15:0] ad, input logic [31:0] exp, input string name);
    xfer(ad, 1'b0, 32'h0, 1'b1, exp, name);
  endtask

  task automatic reset_check(input string name);
    rst_n = 1'b0;
    @(negedge clk);
    push(cyc + 1, 1'b0, 33'h0, {name, "_bus"});
    push(cyc + 1, 1'b1, 33'h0, {name, "_ctrl"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] id_exp [4];
    id_exp = '{32'h4E55_4C4C, 32'h5645_5249, 32'h4C4F_4700, 32'h0000_0000};
    rst_n     = 1'b0;
    avld      = 1'b0;
    addr      = '0;
    wvld      = 1'b0;
    wdata     = '0;
    fpga_id   = 3'd5;
    cnt_event = 2'b00;
    @(negedge clk);
    reset_check("reset");

    for (int k = 0; k < 4; k++) rd(16'(k), id_exp[k], "id");
    rd(16'd4, Stat, "status");

    // ID region is read-only and not an error.
    xfer(16'd1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h5645_5249, "id_wr_old");
    rd(16'd1, 32'h5645_5249, "id_wr_ignored");
    rd(16'd4, Stat, "id_wr_no_err");

    xfer(16'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0, "ctrl_rd_during_wr");
    push(cyc + 1, 1'b1, {1'b0, 32'hDEAD_BEEF}, "ctrl_out");
    rd(16'd5, 32'hDEAD_BEEF, "ctrl_rd");

    for (int i = 0; i < 4; i++) xfer(16'(6 + i), 1'b1, 32'hA5A5_A5A5 + 32'(i), 1'b1, 32'h0, "scr_old");
    for (int i = 0; i < 4; i++) rd(16'(6 + i), 32'hA5A5_A5A5 + 32'(i), "scr_rd");

    // Counter 0 saturates at 15 after 20 pulses; counter 1 sees 3.
    cnt_event = 2'b01;
    repeat (17) @(negedge clk);
    cnt_event = 2'b11;
    repeat (3) @(negedge clk);
    cnt_event = 2'b00;
    rd(16'd10, 32'hF, "cnt0_sat");
    rd(16'd11, 32'h3, "cnt1");
    xfer(16'd10, 1'b1, 32'h1234, 1'b1, 32'hF, "cnt0_rd_at_clr");
    cnt_event = 2'b01;
    @(negedge clk);
    cnt_event = 2'b00;
    rd(16'd10, 32'h0, "cnt0_clr_wins");
    cnt_event = 2'b01;
    repeat (3) @(negedge clk);
    cnt_event = 2'b00;
    rd(16'd10, 32'h3, "cnt0_after_clr");
    xfer(16'd11, 1'b1, 32'h0, 1'b1, 32'h3, "cnt1_rd_at_clr");
    rd(16'd11, 32'h0, "cnt1_clr");

    rd(16'h0100, 32'h0, "oor_rd");
    rd(16'd4, Bad | Stat, "bad_set_rd");
    xfer(16'd4, 1'b1, 32'h8000_0000, 1'b1, Bad | Stat, "bad_clr_old");
    rd(16'd4, Stat, "bad_cleared");
    xfer(16'h0200, 1'b1, 32'h5555_5555, 1'b1, 32'h0, "oor_wr");
    xfer(16'd4, 1'b1, 32'h7FFF_FFFF, 1'b1, Bad | Stat, "bad_set_wr");
    rd(16'd4, Bad | Stat, "bad_no_clr_bit31_0");
    xfer(16'd4, 1'b1, 32'h8000_0000, 1'b0, 32'h0, "");
    rd(16'd4, Stat, "bad_cleared2");

`ifdef REG_FREERUN_CNT_EN
    xfer(16'd12, 1'b1, 32'h0, 1'b0, 32'h0, "");
    rd(16'd12, 32'h0, "fr_lo_after_clr");
    rd(16'd13, 32'h0, "fr_hi_snap");
    rd(16'd4, Stat, "fr_no_err");
`else
    rd(16'd12, 32'h0, "fr_lo_oor");
    rd(16'd4, Bad | Stat, "fr_lo_sets_bad");
    xfer(16'd4, 1'b1, 32'h8000_0000, 1'b0, 32'h0, "");
    rd(16'd13, 32'h0, "fr_hi_oor");
    rd(16'd4, Bad | Stat, "fr_hi_sets_bad");
`endif

    // Reset while a write is pending: the write must be dropped.
    xfer(16'd5, 1'b1, 32'h1234_5678, 1'b0, 32'h0, "");
    reset_check("reset2");
    rd(16'd5, 32'h0, "ctrl_after_rst");
    for (int i = 0; i < 4; i++) rd(16'(6 + i), 32'h0, "scr_after_rst");
    rd(16'd10, 32'h0, "cnt_after_rst");
    rd(16'd4, Stat, "status_after_rst");

    repeat (4) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
